// File: rtl/dmem_mmio_bridge_pkg.sv
// rtl/dmem_mmio_bridge_pkg.sv - shared MMIO map, STATUS layout and reset constants for dmem_mmio_bridge
// Contents:
//   MMIO_BASE_BIT  address bit that selects the MMIO region
//   OFF_*          MMIO register offsets, decoded on DMEM_addr[3:2]
//   ST_*           STATUS register bit positions
//   MTIMECMP_RST   MTIMECMP reset value (timer interrupt parked off)
//   status_word()  packs the STATUS read value
package dmem_mmio_bridge_pkg;

    localparam int MMIO_BASE_BIT = 31;

    localparam logic [1:0] OFF_TX_DATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS   = 2'd1;
    localparam logic [1:0] OFF_MTIME    = 2'd2;
    localparam logic [1:0] OFF_MTIMECMP = 2'd3;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_COUNT_LSB = 3;
    localparam int ST_COUNT_W   = 5;

    localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

    function automatic logic [31:0] status_word(
        input logic                  full,
        input logic                  empty,
        input logic                  overflow,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [31:0] w;
        w                              = '0;
        w[ST_FULL]                     = full;
        w[ST_EMPTY]                    = empty;
        w[ST_OVERFLOW]                 = overflow;
        w[ST_COUNT_LSB +: ST_COUNT_W]  = count;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_bridge_sync_fifo.sv
// rtl/dmem_mmio_bridge_sync_fifo.sv - single-clock FIFO used as the console TX queue
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (pointers and count only)
//   push, push_data      write request and data; ignored when full unless popping too
//   pop                  read request; ignored when empty
//   head_data            entry at the read pointer
//   full, empty, count   occupancy status
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push alongside a pop; an empty FIFO cannot pop, so push-with-pop only pushes.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// rtl/dmem_mmio_bridge.sv - core data-memory port split into a RAM window and an MMIO block
// Ports:
//   Clk, Reset_n                          clock, asynchronous active-low reset
//   DMEM_addr/wr_data/wr_en/rst           core data port; DMEM_rst clears the next read beat
//   DMEM_rd_data                          read data, one cycle after the address
//   ram_addr/ram_wr_data/ram_wr_en        RAM request, combinational from the core port
//   ram_rd_data                           RAM read data, one cycle after ram_addr
//   tx_data/tx_valid/tx_ready             console byte stream from the TX FIFO head
//   Timer_irq                             registered MTIME >= MTIMECMP
module dmem_mmio_bridge
    import dmem_mmio_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RAM_AW     = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [31:0]       DMEM_addr,
    input  logic [31:0]       DMEM_wr_data,
    input  logic              DMEM_wr_en,
    input  logic              DMEM_rst,
    output logic [31:0]       DMEM_rd_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wr_data,
    output logic              ram_wr_en,
    input  logic [31:0]       ram_rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              Timer_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          is_mmio;
    logic [1:0]    mmio_off;
    logic          mmio_wr;
    logic          wr_tx;
    logic          wr_status;
    logic          wr_mtime;
    logic          wr_mtimecmp;
    logic          tx_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          ovf_set;
    logic          overflow;
    logic [31:0]   mtime;
    logic [31:0]   mtimecmp;
    logic [31:0]   mmio_rd_next;
    logic [31:0]   mmio_rd_q;
    logic          sel_mmio_q;
    logic          rd_live_q;
    logic          unused_addr_bits;

    assign is_mmio  = DMEM_addr[MMIO_BASE_BIT];
    assign mmio_off = DMEM_addr[3:2];

    // Upper offset bits are not decoded, so the four registers alias across the MMIO region.
    assign unused_addr_bits = ^{DMEM_addr[30:RAM_AW+2], DMEM_addr[1:0]};

    assign ram_addr    = DMEM_addr[RAM_AW+1:2];
    assign ram_wr_data = DMEM_wr_data;
    assign ram_wr_en   = DMEM_wr_en & ~is_mmio;

    assign mmio_wr     = DMEM_wr_en & is_mmio;
    assign wr_tx       = mmio_wr & (mmio_off == OFF_TX_DATA);
    assign wr_status   = mmio_wr & (mmio_off == OFF_STATUS);
    assign wr_mtime    = mmio_wr & (mmio_off == OFF_MTIME);
    assign wr_mtimecmp = mmio_wr & (mmio_off == OFF_MTIMECMP);

    assign tx_valid = ~fifo_empty;
    assign tx_pop   = tx_valid & tx_ready;

    // The byte is only lost when the FIFO is full and nothing leaves this cycle.
    assign ovf_set  = wr_tx & fifo_full & ~tx_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (wr_tx),
        .push_data (DMEM_wr_data[7:0]),
        .pop       (tx_pop),
        .head_data (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        mmio_rd_next = '0;
        case (mmio_off)
            OFF_TX_DATA:  mmio_rd_next = {24'b0, tx_data};
            OFF_STATUS:   mmio_rd_next = status_word(fifo_full, fifo_empty, overflow,
                                                     ST_COUNT_W'(fifo_count));
            OFF_MTIME:    mmio_rd_next = mtime;
            OFF_MTIMECMP: mmio_rd_next = mtimecmp;
            default:      mmio_rd_next = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            overflow   <= 1'b0;
            mtime      <= '0;
            mtimecmp   <= MTIMECMP_RST;
            Timer_irq  <= 1'b0;
            sel_mmio_q <= 1'b0;
            mmio_rd_q  <= '0;
            rd_live_q  <= 1'b0;
        end else begin
            // Set wins over a same-cycle software clear.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (wr_status && DMEM_wr_data[ST_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            mtime <= wr_mtime ? DMEM_wr_data : mtime + 32'd1;
            if (wr_mtimecmp) begin
                mtimecmp <= DMEM_wr_data;
            end
            Timer_irq  <= (mtime >= mtimecmp);
            sel_mmio_q <= is_mmio;
            mmio_rd_q  <= DMEM_rst ? '0 : mmio_rd_next;
            rd_live_q  <= ~DMEM_rst;
        end
    end

    // rd_live_q also forces zero during reset, when ram_rd_data is not under our control.
    assign DMEM_rd_data = !rd_live_q ? '0 : (sel_mmio_q ? mmio_rd_q : ram_rd_data);

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// tb/tb_dmem_mmio_bridge.sv - directed scoreboard bench for dmem_mmio_bridge
module tb_dmem_mmio_bridge;

    localparam int DEPTH = 4;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] DMEM_addr;
    logic [31:0] DMEM_wr_data;
    logic        DMEM_wr_en;
    logic        DMEM_rst;
    logic [31:0] DMEM_rd_data;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wr_data;
    logic        ram_wr_en;
    logic [31:0] ram_rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        Timer_irq;

    int          vecs;
    int          errs;
    logic [31:0] rdq[$];
    logic [7:0]  txq[$];
    bit          m_ovf;
    logic [31:0] ram [1024];

    dmem_mmio_bridge #(.FIFO_DEPTH(DEPTH), .RAM_AW(10)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DMEM_addr    (DMEM_addr),
        .DMEM_wr_data (DMEM_wr_data),
        .DMEM_wr_en   (DMEM_wr_en),
        .DMEM_rst     (DMEM_rst),
        .DMEM_rd_data (DMEM_rd_data),
        .ram_addr     (ram_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_wr_en    (ram_wr_en),
        .ram_rd_data  (ram_rd_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .Timer_irq    (Timer_irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous RAM: read data appears one cycle after the address.
    always @(posedge Clk) begin
        if (ram_wr_en) ram[ram_addr] <= ram_wr_data;
        ram_rd_data <= ram[ram_addr];
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        DMEM_addr    = a;
        DMEM_wr_data = d;
        DMEM_wr_en   = 1'b1;
        cyc();
        DMEM_wr_en   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input bit clr);
        DMEM_addr  = a;
        DMEM_wr_en = 1'b0;
        DMEM_rst   = clr;
        rdq.push_back(exp);
        cyc();
        check32(tag, DMEM_rd_data, rdq.pop_front());
        DMEM_rst   = 1'b0;
    endtask

    // One cycle on the console path: the model pops before it pushes, so a
    // full FIFO with a pop still takes the new byte.
    task automatic step_tx(input bit do_push, input logic [7:0] b);
        bit pop_now;
        pop_now = tx_ready && (txq.size() > 0);
        check32("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() > 0});
        if (pop_now) check32("tx_data", {24'b0, tx_data}, {24'b0, txq.pop_front()});
        if (do_push) begin
            DMEM_addr    = 32'h8000_0000;
            DMEM_wr_data = {24'b0, b};
            DMEM_wr_en   = 1'b1;
            if (txq.size() < DEPTH) txq.push_back(b);
            else m_ovf = 1'b1;
        end
        cyc();
        DMEM_wr_en = 1'b0;
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 12 && txq.size() > 0; i++) step_tx(1'b0, 8'h00);
        check32("drained_tx_valid", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = 0; errs = 0; m_ovf = 1'b0;
        Reset_n = 1'b0; DMEM_addr = '0; DMEM_wr_data = '0; DMEM_wr_en = 1'b0;
        DMEM_rst = 1'b0; tx_ready = 1'b0;
        #3;
        check32("rst_rd_data", DMEM_rd_data, 32'd0);
        check32("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
        check32("rst_irq", {31'b0, Timer_irq}, 32'd0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
        rd("rst_status", 32'h8000_0004, 32'h02, 1'b0);
        rd("rst_mtimecmp", 32'h8000_000C, 32'hFFFF_FFFF, 1'b0);

        // Scenario 1: RAM write then read
        DMEM_addr = 32'h0000_0010; DMEM_wr_data = 32'h1234_5678; DMEM_wr_en = 1'b1;
        #1;
        check32("ram_wr_en", {31'b0, ram_wr_en}, 32'd1);
        check32("ram_addr", {22'b0, ram_addr}, 32'd4);
        cyc();
        DMEM_wr_en = 1'b0;
        rd("ram_rd", 32'h0000_0010, 32'h1234_5678, 1'b0);
        wr(32'h0000_0FFC, 32'hA5A5_0FFC);
        rd("ram_rd_top", 32'h0000_0FFC, 32'hA5A5_0FFC, 1'b0);
        rd("ram_rd_again", 32'h0000_0010, 32'h1234_5678, 1'b0);

        // Scenario 2: overfill, then drain in order
        for (int i = 0; i < 5; i++) step_tx(1'b1, 8'h41 + 8'(i));
        rd("status_full_ovf", 32'h8000_0004, 32'h25, 1'b0);
        drain();
        rd("status_drained", 32'h8000_0004, 32'h06, 1'b0);
        wr(32'h8000_0004, 32'h4);
        m_ovf = 1'b0;
        rd("status_ovf_clr", 32'h8000_0004, 32'h02, 1'b0);

        // Scenario 3: push and pop together on a full FIFO
        for (int i = 0; i < 4; i++) step_tx(1'b1, 8'h51 + 8'(i));
        tx_ready = 1'b1;
        step_tx(1'b1, 8'h55);
        tx_ready = 1'b0;
        rd("status_full_pp", 32'h8000_0004, 32'h21, 1'b0);
        drain();

        // Scenario 4: MTIME wrap and timer interrupt
        DMEM_addr = 32'h8000_0008; DMEM_wr_data = 32'hFFFF_FFFE; DMEM_wr_en = 1'b1;
        #1;
        check32("mmio_no_ram_wr", {31'b0, ram_wr_en}, 32'd0);
        cyc();
        DMEM_wr_en = 1'b0;
        wr(32'h8000_000C, 32'h0000_0002);
        rd("mtime_ffff", 32'h8000_0008, 32'hFFFF_FFFF, 1'b0);
        rd("mtime_wrap", 32'h8000_0008, 32'h0000_0000, 1'b0);
        check32("irq_at_1", {31'b0, Timer_irq}, 32'd0);
        cyc();
        check32("irq_at_2", {31'b0, Timer_irq}, 32'd0);
        rd("mtime_2", 32'h8000_0008, 32'h0000_0002, 1'b0);
        check32("irq_rise", {31'b0, Timer_irq}, 32'd1);

        // Scenario 5: reset mid-drain with 3 bytes queued
        for (int i = 0; i < 3; i++) step_tx(1'b1, 8'h61 + 8'(i));
        tx_ready = 1'b1;
        #1;
        check32("pre_rst_valid", {31'b0, tx_valid}, 32'd1);
        check32("pre_rst_irq", {31'b0, Timer_irq}, 32'd1);
        Reset_n = 1'b0;
        #1;
        check32("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
        check32("mid_rst_irq", {31'b0, Timer_irq}, 32'd0);
        txq.delete();
        m_ovf    = 1'b0;
        tx_ready = 1'b0;
        cyc();
        Reset_n = 1'b1;
        rd("post_rst_status", 32'h8000_0004, 32'h02, 1'b0);
        rd("post_rst_mtimecmp", 32'h8000_000C, 32'hFFFF_FFFF, 1'b0);

        // Scenario 6: DMEM_rst clears the read beat; offset alias; TX_DATA peek
        rd("mtime_dmem_rst", 32'h8000_0008, 32'h0, 1'b1);
        wr(32'h8000_000C, 32'hCAFE_0001);
        rd("mtimecmp_alias", 32'h8000_001C, 32'hCAFE_0001, 1'b0);
        step_tx(1'b1, 8'h77);
        rd("tx_data_peek", 32'h8000_0000, 32'h77, 1'b0);
        rd("status_no_pop", 32'h8000_0004, 32'h08, 1'b0);
        rd("ram_after_rst", 32'h0000_0010, 32'h1234_5678, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_bridge.md
DMEM_MMIO_BRIDGE -- requirements
Module: dmem_mmio_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, is the console TX FIFO depth; it SHALL be a power of two and at least 2.
REQ-002 Parameter RAM_AW, default 10, is the RAM word-address width (4 KiB RAM).
REQ-003 Port Clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port DMEM_addr, input, 32 bits: byte address from the core.
REQ-006 Port DMEM_wr_data, input, 32 bits: write data from the core.
REQ-007 Port DMEM_wr_en, input, 1 bit: write strobe from the core.
REQ-008 Port DMEM_rst, input, 1 bit: synchronous clear of the read path.
REQ-009 Port DMEM_rd_data, output, 32 bits: read data returned to the core.
REQ-010 Port ram_addr, output, RAM_AW bits: word address to the RAM.
REQ-011 Port ram_wr_data, output, 32 bits: write data to the RAM.
REQ-012 Port ram_wr_en, output, 1 bit: RAM write strobe.
REQ-013 Port ram_rd_data, input, 32 bits: RAM read data, valid one cycle after ram_addr.
REQ-014 Port tx_data, output, 8 bits: byte at the console FIFO head.
REQ-015 Port tx_valid, output, 1 bit: console FIFO is non-empty.
REQ-016 Port tx_ready, input, 1 bit: console sink accepts the head byte.
REQ-017 Port Timer_irq, output, 1 bit: registered timer interrupt.

Function
REQ-018 The RAM region is DMEM_addr[31] = 0; within it, ram_addr SHALL equal DMEM_addr[RAM_AW+1:2] and ram_wr_en SHALL equal DMEM_wr_en, both combinational.
REQ-019 The MMIO region is DMEM_addr[31] = 1, decoded on DMEM_addr[3:2]:
  - 0 = TX_DATA
  - 1 = STATUS
  - 2 = MTIME
  - 3 = MTIMECMP
REQ-020 DMEM_rd_data SHALL have a latency of exactly one cycle for both regions.
REQ-021 The region select SHALL be registered, and the registered select SHALL pick between ram_rd_data and the registered MMIO read value.
REQ-022 A write to TX_DATA SHALL push DMEM_wr_data[7:0] into the FIFO.
REQ-023 A push to a full FIFO SHALL drop the byte and set the sticky overflow bit.
REQ-024 A pop SHALL occur when tx_valid and tx_ready are both high.
REQ-025 A simultaneous push and pop on a full FIFO SHALL both succeed and leave the count unchanged.
REQ-026 A simultaneous push and pop on an empty FIFO SHALL only push.
REQ-027 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 STATUS read value SHALL be:
  - bit0 = full
  - bit1 = empty
  - bit2 = overflow
  - bits[7:3] = count
  - all other bits zero
REQ-029 A write to STATUS with bit2 = 1 SHALL clear overflow; if an overflowing push happens in the same cycle, set SHALL win.
REQ-030 MTIME SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-031 A write to MTIME SHALL load DMEM_wr_data, taking priority over that cycle's increment.
REQ-032 A write to MTIMECMP SHALL load DMEM_wr_data.
REQ-033 Timer_irq SHALL be registered as (MTIME >= MTIMECMP), using unsigned comparison of current register values.
REQ-034 A read of TX_DATA SHALL return zero-extended tx_data, with no pop.
REQ-035 MMIO writes SHALL never assert ram_wr_en.
REQ-036 When DMEM_rst is high, DMEM_rd_data SHALL be zero in the following cycle; writes proceed normally.

Reset
REQ-037 While Reset_n is low, the following SHALL be zero asynchronously:
  - DMEM_rd_data
  - FIFO pointers and count (so tx_valid = 0)
  - overflow
  - MTIME
  - Timer_irq
  - the registered region select
REQ-038 While Reset_n is low, MTIMECMP SHALL be 0xFFFF_FFFF.
REQ-039 FIFO storage SHALL NOT require reset.
REQ-040 Reset asserted mid-operation SHALL discard queued bytes, with tx_valid low in the same cycle.

Structure
REQ-041 A shared package SHALL hold:
  - MMIO offsets
  - STATUS bit positions
  - the MMIO base decode bit
  - the MTIMECMP reset constant
REQ-042 The TX FIFO SHALL be one sub-module, sync_fifo, parameterised by width 8 and FIFO_DEPTH, exposing full, empty, count and push/pop.

Verification
REQ-043 Scenario 1: write 0x1234_5678 to 0x0000_0010, then read it -> ram_wr_en pulses with ram_addr = 4, and DMEM_rd_data = 0x1234_5678 one cycle after the read address.
REQ-044 Scenario 2: with tx_ready = 0, push 5 bytes 0x41..0x45 -> STATUS = 0x25 (full, overflow, count 4); then set tx_ready = 1 -> 0x41..0x44 drain in order, and STATUS = 0x06.
REQ-045 Scenario 3: with the FIFO full, push and pop in the same cycle -> count stays 4, overflow stays 0, and the new byte appears last.
REQ-046 Scenario 4: write MTIME = 0xFFFF_FFFE, MTIMECMP = 0x0000_0002 -> MTIME wraps to 0 after 2 cycles, and Timer_irq rises one cycle after MTIME reaches 2.
REQ-047 Scenario 5: assert Reset_n low mid-drain with 3 bytes queued -> tx_valid = 0 and Timer_irq = 0 immediately, and after release STATUS reads 0x02.
REQ-048 Scenario 6: read MTIME with DMEM_rst = 1 -> DMEM_rd_data = 0 next cycle; read an unmapped MMIO offset via MTIMECMP alias check (0x8000_001C) -> returns MTIMECMP.
